// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared constants, state encoding and output bundle for the 8-point FFT sequencer
package fft8_pkg;

  localparam int N              = 8;
  localparam int STAGES         = 3;
  localparam int BFLY_PER_STAGE = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_FIN,
    ST_OUT
  } state_e;

  typedef struct packed {
    logic       rd_en;
    logic [2:0] rd_add1;
    logic [2:0] rd_add2;
    logic       wr_en;
    logic [2:0] wr_add1;
    logic [2:0] wr_add2;
    logic [1:0] tw_idx;
    logic       wd_finish;
    logic [2:0] read_addr;
    logic       out_valid;
    logic       busy;
    logic       overrun;
  } ctrl_out_t;

endpackage

// File: rtl/fft8_addr_gen.sv
// rtl/fft8_addr_gen.sv - combinational butterfly operand addresses and twiddle index for (stage, butterfly)
module fft8_addr_gen
  import fft8_pkg::*;
(
  input  logic [1:0] s,
  input  logic [1:0] k,
  output logic [2:0] add1,
  output logic [2:0] add2,
  output logic [1:0] tw
);

  logic [2:0] span;
  logic [1:0] grp;
  logic [1:0] pos;
  logic [2:0] base;

  // base = grp * 2 * span always fits in 3 bits for s <= 2
  always_comb begin
    span = 3'd1 << s;
    grp  = k >> s;
    pos  = k & (span[1:0] - 2'd1);
    base = {1'b0, grp} << (s + 2'd1);
    add1 = base + {1'b0, pos};
    add2 = add1 + span;
    tw   = pos << (2'd2 - s);
  end

endmodule

// File: rtl/fft8_seq_ctrl.sv
// rtl/fft8_seq_ctrl.sv - sequences the 12 radix-2 butterflies of an 8-point FFT, then reads results out
module fft8_seq_ctrl
  import fft8_pkg::*;
#(
  parameter int unsigned BF_LAT = 2
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       initial_flag,
  output logic       rd_en,
  output logic [2:0] rd_add1,
  output logic [2:0] rd_add2,
  output logic       wr_en,
  output logic [2:0] wr_add1,
  output logic [2:0] wr_add2,
  output logic [1:0] tw_idx,
  output logic       wd_finish,
  output logic [2:0] read_addr,
  output logic       out_valid,
  output logic       busy,
  output logic       overrun
);

  localparam logic [3:0] WAIT_LAST = 4'(BF_LAT - 1);
  localparam logic [1:0] LAST_S    = 2'(STAGES - 1);
  localparam logic [1:0] LAST_K    = 2'(BFLY_PER_STAGE - 1);
  localparam logic [3:0] OUT_LAST  = 4'(N - 1);

  state_e     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [1:0] k_q, k_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_out_t  out_q, out_d;

  logic [2:0] ag_add1, ag_add2;
  logic [1:0] ag_tw;

  // Fed from the next (s,k) so registered addresses line up with the rd/wr cycle
  fft8_addr_gen u_addr_gen (
    .s    (s_d),
    .k    (k_d),
    .add1 (ag_add1),
    .add2 (ag_add2),
    .tw   (ag_tw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // cnt_q counts WAIT cycles during butterflies and the readout index during OUT
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (initial_flag) state_d = ST_RD;
      ST_RD: begin
        if (BF_LAT > 1) begin
          state_d = ST_WAIT;
          cnt_d   = 4'd1;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WAIT: begin
        if (cnt_q >= WAIT_LAST) begin
          state_d = ST_WR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WR: begin
        if (s_q == LAST_S && k_q == LAST_K) begin
          state_d = ST_FIN;
          s_d     = '0;
          k_d     = '0;
        end else begin
          state_d = ST_RD;
          k_d     = k_q + 2'd1;
          if (k_q == LAST_K) s_d = s_q + 2'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_OUT;
        cnt_d   = '0;
      end
      ST_OUT: begin
        if (cnt_q == OUT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        k_d     = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_d = '0;
    if (state_d == ST_RD) begin
      out_d.rd_en   = 1'b1;
      out_d.rd_add1 = ag_add1;
      out_d.rd_add2 = ag_add2;
      out_d.tw_idx  = ag_tw;
    end
    if (state_d == ST_WR) begin
      out_d.wr_en   = 1'b1;
      out_d.wr_add1 = ag_add1;
      out_d.wr_add2 = ag_add2;
    end
    if (state_d == ST_OUT) begin
      out_d.rd_en     = 1'b1;
      out_d.out_valid = 1'b1;
      out_d.read_addr = cnt_d[2:0];
    end
    out_d.wd_finish = (state_d == ST_FIN);
    out_d.busy      = (state_d != ST_IDLE);
    out_d.overrun   = initial_flag && (state_q != ST_IDLE);
  end

  assign rd_en     = out_q.rd_en;
  assign rd_add1   = out_q.rd_add1;
  assign rd_add2   = out_q.rd_add2;
  assign wr_en     = out_q.wr_en;
  assign wr_add1   = out_q.wr_add1;
  assign wr_add2   = out_q.wr_add2;
  assign tw_idx    = out_q.tw_idx;
  assign wd_finish = out_q.wd_finish;
  assign read_addr = out_q.read_addr;
  assign out_valid = out_q.out_valid;
  assign busy      = out_q.busy;
  assign overrun   = out_q.overrun;

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// tb/tb_fft8_seq_ctrl.sv - self-checking bench for fft8_seq_ctrl at BF_LAT=2 and BF_LAT=1
module tb_fft8_seq_ctrl;

  typedef struct packed {
    logic       rd_en;
    logic [2:0] rd_add1;
    logic [2:0] rd_add2;
    logic       wr_en;
    logic [2:0] wr_add1;
    logic [2:0] wr_add2;
    logic [1:0] tw_idx;
    logic       wd_finish;
    logic [2:0] read_addr;
    logic       out_valid;
    logic       busy;
    logic       overrun;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic initial_flag = 1'b0;

  logic       a_rd_en, a_wr_en, a_wd_finish, a_out_valid, a_busy, a_overrun;
  logic [2:0] a_rd_add1, a_rd_add2, a_wr_add1, a_wr_add2, a_read_addr;
  logic [1:0] a_tw_idx;
  logic       b_rd_en, b_wr_en, b_wd_finish, b_out_valid, b_busy, b_overrun;
  logic [2:0] b_rd_add1, b_rd_add2, b_wr_add1, b_wr_add2, b_read_addr;
  logic [1:0] b_tw_idx;

  int n_checks = 0;
  int n_fail = 0;

  // Butterfly operand pairs and twiddles in issue order
  int a_tab [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int b_tab [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int w_tab [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  always #5 clk = ~clk;

  fft8_seq_ctrl #(.BF_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .initial_flag(initial_flag),
    .rd_en(a_rd_en), .rd_add1(a_rd_add1), .rd_add2(a_rd_add2),
    .wr_en(a_wr_en), .wr_add1(a_wr_add1), .wr_add2(a_wr_add2),
    .tw_idx(a_tw_idx), .wd_finish(a_wd_finish), .read_addr(a_read_addr),
    .out_valid(a_out_valid), .busy(a_busy), .overrun(a_overrun)
  );

  fft8_seq_ctrl #(.BF_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .initial_flag(initial_flag),
    .rd_en(b_rd_en), .rd_add1(b_rd_add1), .rd_add2(b_rd_add2),
    .wr_en(b_wr_en), .wr_add1(b_wr_add1), .wr_add2(b_wr_add2),
    .tw_idx(b_tw_idx), .wd_finish(b_wd_finish), .read_addr(b_read_addr),
    .out_valid(b_out_valid), .busy(b_busy), .overrun(b_overrun)
  );

  function automatic obs_t obs2();
    return '{a_rd_en, a_rd_add1, a_rd_add2, a_wr_en, a_wr_add1, a_wr_add2,
             a_tw_idx, a_wd_finish, a_read_addr, a_out_valid, a_busy, a_overrun};
  endfunction

  function automatic obs_t obs1();
    return '{b_rd_en, b_rd_add1, b_rd_add2, b_wr_en, b_wr_add1, b_wr_add2,
             b_tw_idx, b_wd_finish, b_read_addr, b_out_valid, b_busy, b_overrun};
  endfunction

  // Expected outputs t cycles after initial_flag was sampled (t=1 is the first read)
  function automatic obs_t model(int lat, int t, bit ovr);
    obs_t e;
    int tot;
    int bf;
    int ph;
    e = '0;
    tot = 12 * (lat + 1);
    if (t >= 1 && t <= tot) begin
      bf = (t - 1) / (lat + 1);
      ph = (t - 1) % (lat + 1);
      if (ph == 0) begin
        e.rd_en   = 1'b1;
        e.rd_add1 = 3'(a_tab[bf]);
        e.rd_add2 = 3'(b_tab[bf]);
        e.tw_idx  = 2'(w_tab[bf]);
      end
      if (ph == lat) begin
        e.wr_en   = 1'b1;
        e.wr_add1 = 3'(a_tab[bf]);
        e.wr_add2 = 3'(b_tab[bf]);
      end
    end
    if (t == tot + 1) e.wd_finish = 1'b1;
    if (t >= tot + 2 && t <= tot + 9) begin
      e.rd_en     = 1'b1;
      e.out_valid = 1'b1;
      e.read_addr = 3'(t - tot - 2);
    end
    e.busy    = (t >= 1 && t <= tot + 9);
    e.overrun = ovr;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t z;
    z = '0;
    rst = 1'b0;
    initial_flag = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (obs2() !== z) begin n_fail++; $display("FAIL reset_hold_lat2 got=%h exp=%h", obs2(), z); end
    n_checks++;
    if (obs1() !== z) begin n_fail++; $display("FAIL reset_hold_lat1 got=%h exp=%h", obs1(), z); end
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (obs2() !== z) begin n_fail++; $display("FAIL reset_idle_lat2 got=%h exp=%h", obs2(), z); end
    n_checks++;
    if (obs1() !== z) begin n_fail++; $display("FAIL reset_idle_lat1 got=%h exp=%h", obs1(), z); end
  endtask

  task automatic test_transform(int gap);
    obs_t e;
    for (int g = 0; g < gap; g++) begin
      tick();
      e = model(2, 0, 1'b0);
      n_checks++;
      if (obs2() !== e) begin n_fail++; $display("FAIL idle_gap_lat2 g=%0d got=%h exp=%h", g, obs2(), e); end
    end
    initial_flag = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      initial_flag = 1'b0;
      e = model(2, t, 1'b0);
      n_checks++;
      if (obs2() !== e) begin n_fail++; $display("FAIL transform_lat2 t=%0d got=%h exp=%h", t, obs2(), e); end
      e = model(1, t, 1'b0);
      n_checks++;
      if (obs1() !== e) begin n_fail++; $display("FAIL transform_lat1 t=%0d got=%h exp=%h", t, obs1(), e); end
    end
  endtask

  task automatic test_overrun(int p);
    obs_t e;
    initial_flag = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      initial_flag = 1'b0;
      e = model(2, t, t == p + 1);
      n_checks++;
      if (obs2() !== e) begin n_fail++; $display("FAIL overrun_lat2 p=%0d t=%0d got=%h exp=%h", p, t, obs2(), e); end
      e = model(1, t, t == p + 1);
      n_checks++;
      if (obs1() !== e) begin n_fail++; $display("FAIL overrun_lat1 p=%0d t=%0d got=%h exp=%h", p, t, obs1(), e); end
      if (t == p) initial_flag = 1'b1;
    end
  endtask

  task automatic test_reset_abort(int rc);
    obs_t e;
    obs_t z;
    z = '0;
    initial_flag = 1'b1;
    for (int t = 1; t <= rc; t++) begin
      tick();
      initial_flag = 1'b0;
      e = model(2, t, 1'b0);
      n_checks++;
      if (obs2() !== e) begin n_fail++; $display("FAIL abort_pre_lat2 t=%0d got=%h exp=%h", t, obs2(), e); end
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs2() !== z) begin n_fail++; $display("FAIL abort_async_lat2 rc=%0d got=%h exp=%h", rc, obs2(), z); end
    n_checks++;
    if (obs1() !== z) begin n_fail++; $display("FAIL abort_async_lat1 rc=%0d got=%h exp=%h", rc, obs1(), z); end
    tick();
    rst = 1'b1;
    for (int t = 0; t < 50; t++) begin
      tick();
      n_checks++;
      if (obs2() !== z) begin n_fail++; $display("FAIL abort_idle_lat2 t=%0d got=%h exp=%h", t, obs2(), z); end
      n_checks++;
      if (obs1() !== z) begin n_fail++; $display("FAIL abort_idle_lat1 t=%0d got=%h exp=%h", t, obs1(), z); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    initial_flag = 1'b1;
    for (int t = 1; t <= 46; t++) begin
      tick();
      initial_flag = 1'b0;
      e = model(2, t, 1'b0);
      n_checks++;
      if (obs2() !== e) begin n_fail++; $display("FAIL b2b_first_lat2 t=%0d got=%h exp=%h", t, obs2(), e); end
      e = model(1, t, 1'b0);
      n_checks++;
      if (obs1() !== e) begin n_fail++; $display("FAIL b2b_first_lat1 t=%0d got=%h exp=%h", t, obs1(), e); end
    end
    initial_flag = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      initial_flag = 1'b0;
      e = model(2, t, 1'b0);
      n_checks++;
      if (obs2() !== e) begin n_fail++; $display("FAIL b2b_second_lat2 t=%0d got=%h exp=%h", t, obs2(), e); end
      e = model(1, t, 1'b0);
      n_checks++;
      if (obs1() !== e) begin n_fail++; $display("FAIL b2b_second_lat1 t=%0d got=%h exp=%h", t, obs1(), e); end
    end
  endtask

  initial begin
    test_reset();
    test_transform(0);
    for (int i = 0; i < 3; i++) test_transform(int'($urandom_range(1, 6)));
    test_overrun(10);
    for (int i = 0; i < 3; i++) test_overrun(int'($urandom_range(1, 32)));
    test_reset_abort(20);
    test_reset_abort(int'($urandom_range(2, 44)));
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
